// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 command sequencer: FSM encoding,
// init ROM contents, command opcodes and the delay-load helper.
package lcd_pkg;

    localparam int CNT_W    = 24;
    localparam int INIT_LEN = 7;

    typedef enum logic [2:0] {
        ST_PWR_WAIT  = 3'd0,
        ST_SETUP     = 3'd1,
        ST_E_HIGH    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_EXEC_WAIT = 3'd4,
        ST_IDLE      = 3'd5
    } lcd_state_e;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] INIT_FUNC_SET = 8'h38;
    localparam logic [7:0] INIT_DISP_ON  = 8'h0C;
    localparam logic [7:0] INIT_ENTRY    = 8'h06;

    // Init ROM: four function-set writes, display on, clear, entry mode.
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: init_byte = INIT_FUNC_SET;
            3'd4:                   init_byte = INIT_DISP_ON;
            3'd5:                   init_byte = CMD_CLEAR;
            3'd6:                   init_byte = INIT_ENTRY;
            default:                init_byte = 8'h00;
        endcase
    endfunction

    // A phase of n cycles loads n-1 into the down-counter; 0 behaves as 1.
    function automatic logic [CNT_W-1:0] cyc_load(input int unsigned n);
        cyc_load = (n == 0) ? '0 : CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Single down-counter used for every timed phase; done while it sits at 0.
module lcd_delay_timer
    import lcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load wins over counting; the counter parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = value_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Avalon-MM slave that runs the HD44780 power-on init and then issues
// single host bytes with setup / enable / hold / execution timing.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned POWERON_CYC = 750000,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned EPW_CYC     = 12,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned EXEC_CYC    = 2000,
    parameter int unsigned CLEAR_CYC   = 82000,
    parameter int unsigned INIT1_CYC   = 205000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_data,
    output logic        busy
);

    lcd_state_e       state_q, state_d;
    logic             armed_q, armed_d;
    logic [2:0]       rom_idx_q, rom_idx_d;
    logic             init_done_q, init_done_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       last_byte_q, last_byte_d;
    logic             last_rs_q, last_rs_d;

    logic             tmr_load, tmr_done;
    logic [CNT_W-1:0] tmr_value, exec_load;
    logic             launch, launch_rs;
    logic [7:0]       launch_byte;

    logic             wr_data, wr_clr, accept;
    logic             unused_wdata;

    assign unused_wdata = ^writedata[31:9];

    assign wr_data = chipselect && !write_n && (address == 2'd0);
    assign wr_clr  = chipselect && !write_n && (address == 2'd1);
    assign accept  = wr_data && (state_q == ST_IDLE) && init_done_q;

    lcd_delay_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .done_o  (tmr_done)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_PWR_WAIT;
            armed_q     <= 1'b0;
            rom_idx_q   <= '0;
            init_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            last_byte_q <= '0;
            last_rs_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            rom_idx_q   <= rom_idx_d;
            init_done_q <= init_done_d;
            overrun_q   <= overrun_d;
            last_byte_q <= last_byte_d;
            last_rs_q   <= last_rs_d;
        end
    end

    // Next-state: phase sequencing, init ROM walk, host accept, overrun.
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        rom_idx_d   = rom_idx_q;
        init_done_d = init_done_q;
        last_byte_d = last_byte_q;
        last_rs_d   = last_rs_q;
        tmr_load    = 1'b0;
        tmr_value   = '0;
        launch      = 1'b0;
        launch_byte = last_byte_q;
        launch_rs   = 1'b0;

        // A dropped write and a clear in the same cycle: the set wins.
        if (wr_data && !accept) overrun_d = 1'b1;
        else if (wr_clr)        overrun_d = 1'b0;
        else                    overrun_d = overrun_q;

        // The first two init bytes have their own long waits.
        if (!init_done_q && rom_idx_q == 3'd0)
            exec_load = cyc_load(INIT1_CYC);
        else if (!init_done_q && rom_idx_q == 3'd1)
            exec_load = cyc_load(EXEC_CYC * 3);
        else if (!last_rs_q && (last_byte_q == CMD_CLEAR || last_byte_q == CMD_HOME))
            exec_load = cyc_load(CLEAR_CYC);
        else
            exec_load = cyc_load(EXEC_CYC);

        case (state_q)
            ST_PWR_WAIT: begin
                // The counter comes out of reset at zero, so the first cycle
                // arms it; that cycle counts toward the power-on wait.
                if (!armed_q) begin
                    armed_d = 1'b1;
                    if (POWERON_CYC <= 1) begin
                        launch      = 1'b1;
                        launch_byte = init_byte(rom_idx_q);
                    end else begin
                        tmr_load  = 1'b1;
                        tmr_value = cyc_load(POWERON_CYC - 1);
                    end
                end else if (tmr_done) begin
                    launch      = 1'b1;
                    launch_byte = init_byte(rom_idx_q);
                end
            end
            ST_SETUP: if (tmr_done) begin
                state_d   = ST_E_HIGH;
                tmr_load  = 1'b1;
                tmr_value = cyc_load(EPW_CYC);
            end
            ST_E_HIGH: if (tmr_done) begin
                state_d   = ST_HOLD;
                tmr_load  = 1'b1;
                tmr_value = cyc_load(HOLD_CYC);
            end
            ST_HOLD: if (tmr_done) begin
                state_d   = ST_EXEC_WAIT;
                tmr_load  = 1'b1;
                tmr_value = exec_load;
            end
            ST_EXEC_WAIT: if (tmr_done) begin
                if (init_done_q) begin
                    state_d = ST_IDLE;
                end else if (rom_idx_q == 3'(INIT_LEN - 1)) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    rom_idx_d   = rom_idx_q + 3'd1;
                    launch      = 1'b1;
                    launch_byte = init_byte(rom_idx_q + 3'd1);
                end
            end
            ST_IDLE: if (accept) begin
                launch      = 1'b1;
                launch_byte = writedata[7:0];
                launch_rs   = writedata[8];
            end
            default: state_d = ST_PWR_WAIT;
        endcase

        // Latching the byte at SETUP entry keeps the bus stable through HOLD.
        if (launch) begin
            state_d     = ST_SETUP;
            last_byte_d = launch_byte;
            last_rs_d   = launch_rs;
            tmr_load    = 1'b1;
            tmr_value   = cyc_load(SETUP_CYC);
        end
    end

    // Outputs: strobe and busy decoded from state so reset drops them at once.
    always_comb begin
        lcd_e    = (state_q == ST_E_HIGH);
        busy     = (state_q != ST_IDLE);
        lcd_rw   = 1'b0;
        lcd_rs   = last_rs_q;
        lcd_data = last_byte_q;
        case (address)
            2'd0:    readdata = {23'b0, last_rs_q, last_byte_q};
            2'd1:    readdata = {29'b0, overrun_q, init_done_q, (state_q != ST_IDLE)};
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Bench for lcd_cmd_sequencer: reset values, init replay, table vectors,
// overrun handling, random host traffic and reset during an enable pulse.
module tb_lcd_cmd_sequencer;

    localparam int P_PWR = 20, P_SU = 2, P_EPW = 4, P_HLD = 2;
    localparam int P_EXEC = 10, P_CLR = 50, P_INIT1 = 30;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        lcd_e, lcd_rs, lcd_rw, busy;
    logic [7:0]  lcd_data;

    lcd_cmd_sequencer #(
        .POWERON_CYC(P_PWR), .SETUP_CYC(P_SU), .EPW_CYC(P_EPW), .HOLD_CYC(P_HLD),
        .EXEC_CYC(P_EXEC), .CLEAR_CYC(P_CLR), .INIT1_CYC(P_INIT1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc;

    // Edges since reset release.
    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int rise; logic [7:0] d; logic rs; } pulse_t;
    pulse_t     exp_q[$];
    int         init_end, cur_s, cur_e;
    bit         ovr_m;
    logic [7:0] last_d_m;
    bit         last_rs_m;

    function automatic int wait_of(input logic [7:0] b, input bit rs, input int init_idx);
        if (init_idx == 0) return P_INIT1;
        if (init_idx == 1) return P_EXEC * 3;
        if (!rs && (b == 8'h01 || b == 8'h02)) return P_CLR;
        return P_EXEC;
    endfunction

    // Busy after edge k: still initialising, or inside the current host write.
    function automatic bit model_busy(input int k);
        return (k < init_end) || (k >= cur_s && k < cur_e);
    endfunction

    function automatic logic [31:0] exp_st();
        return {29'b0, ovr_m, (cyc >= init_end), model_busy(cyc)};
    endfunction

    task automatic model_reset();
        logic [7:0] ib [7];
        int s;
        ib = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        exp_q.delete();
        s = P_PWR;
        for (int k = 0; k < 7; k++) begin
            exp_q.push_back('{s + P_SU, ib[k], 1'b0});
            s += P_SU + P_EPW + P_HLD + wait_of(ib[k], 1'b0, k);
        end
        init_end  = s;
        cur_s     = 0;
        cur_e     = 0;
        ovr_m     = 0;
        last_d_m  = 8'h06;
        last_rs_m = 0;
    endtask

    // ---------------- host bus tasks ----------------
    task automatic host_write(input logic [1:0] a, input logic [31:0] d, output int w);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        w = cyc + 1;
        if (a == 2'd0) begin
            if (!model_busy(w - 1)) begin
                cur_s = w;
                cur_e = w + P_SU + P_EPW + P_HLD + wait_of(d[7:0], d[8], -1);
                exp_q.push_back('{w + P_SU, d[7:0], d[8]});
                last_d_m  = d[7:0];
                last_rs_m = d[8];
            end else begin
                ovr_m = 1;
            end
        end else if (a == 2'd1) begin
            ovr_m = 0;
        end
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        @(negedge clk);
        address = a;
        #1 v = readdata;
    endtask

    task automatic wait_idle(input int bound, output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < bound);
        if (busy) begin
            total++; bad++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles", bound);
        end
        t = cyc;
    endtask

    // ---------------- pulse monitor ----------------
    int         r_cyc, last_fall, n_pulses = 0;
    logic [7:0] r_d, last_d_seen;
    logic       r_rs, last_rs_seen;
    bit         in_pulse = 0, stab_ok = 1;

    always @(negedge clk) begin
        if (!reset_n) begin
            in_pulse = 0;
        end else begin
            chk("busy", busy, model_busy(cyc));
            if (lcd_e && !in_pulse) begin
                in_pulse = 1; r_cyc = cyc; r_d = lcd_data; r_rs = lcd_rs; stab_ok = 1;
            end else if (lcd_e) begin
                if (lcd_data !== r_d || lcd_rs !== r_rs) stab_ok = 0;
            end else if (in_pulse) begin
                pulse_t p;
                in_pulse = 0; last_fall = cyc; last_d_seen = r_d; last_rs_seen = r_rs;
                n_pulses++;
                chk("pulse_width", cyc - r_cyc, P_EPW);
                chk("pulse_stable", stab_ok, 1);
                chk("hold_data", {lcd_rs, lcd_data}, {r_rs, r_d});
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pulse: data 0x%0h rs %0d rise %0d", r_d, r_rs, r_cyc);
                end else begin
                    p = exp_q.pop_front();
                    chk("pulse_rise", r_cyc, p.rise);
                    chk("pulse_data", r_d, p.d);
                    chk("pulse_rs", r_rs, p.rs);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct { logic [31:0] wd; logic rs; logic [7:0] d; int gap; int dur; } vec_t;
    vec_t tv [6];

    initial begin
        logic [31:0] v;
        int w, w2, t, np;

        tv[0] = '{32'h141, 1'b1, 8'h41, 12, 18};
        tv[1] = '{32'h001, 1'b0, 8'h01, 52, 58};
        tv[2] = '{32'h00C, 1'b0, 8'h0C, 12, 18};
        tv[3] = '{32'h002, 1'b0, 8'h02, 52, 58};
        tv[4] = '{32'h101, 1'b1, 8'h01, 12, 18};
        tv[5] = '{32'h0FF, 1'b0, 8'hFF, 12, 18};

        model_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_lcd_e", lcd_e, 0);
        chk("rst_lcd_rs", lcd_rs, 0);
        chk("rst_lcd_data", lcd_data, 0);
        chk("rst_lcd_rw", lcd_rw, 0);
        chk("rst_busy", busy, 1);
        rd(2'd1, v); chk("rst_status", v, 32'h1);
        rd(2'd0, v); chk("rst_last", v, 32'h0);

        @(negedge clk) reset_n = 1'b1;

        // Write before init completes: dropped and flagged.
        repeat (10) @(negedge clk);
        host_write(2'd0, 32'h155, w);
        rd(2'd1, v); chk("preinit_ovr", v, 32'h5); chk("preinit_model", v, exp_st());
        host_write(2'd1, 32'h0, w);
        rd(2'd1, v); chk("preinit_clr", v, 32'h1);

        wait_idle(1000, t);
        chk("init_end", t, 226);
        chk("init_pulses", n_pulses, 7);
        rd(2'd1, v); chk("init_status", v, 32'h2);
        rd(2'd0, v); chk("init_last", v, 32'h006);
        rd(2'd2, v); chk("addr2_zero", v, 0);
        rd(2'd3, v); chk("addr3_zero", v, 0);

        // Table vectors: one write each, measured to idle.
        for (int i = 0; i < 6; i++) begin
            host_write(2'd0, tv[i].wd, w);
            wait_idle(200, t);
            chk($sformatf("vec%0d_rs", i), last_rs_seen, tv[i].rs);
            chk($sformatf("vec%0d_data", i), last_d_seen, tv[i].d);
            chk($sformatf("vec%0d_gap", i), t - last_fall, tv[i].gap);
            chk($sformatf("vec%0d_dur", i), t - w, tv[i].dur);
            rd(2'd0, v); chk($sformatf("vec%0d_rd", i), v, {23'b0, tv[i].rs, tv[i].d});
        end

        // Second write while busy is dropped; clearing leaves busy|init_done.
        np = n_pulses;
        host_write(2'd0, 32'h141, w);
        repeat (2) @(negedge clk);
        host_write(2'd0, 32'h0AA, w2);
        rd(2'd1, v); chk("ovr_status", v, 32'h7);
        host_write(2'd1, 32'h0, w2);
        rd(2'd1, v); chk("ovr_cleared", v, 32'h3);
        wait_idle(200, t);
        chk("ovr_pulses", n_pulses - np, 1);
        rd(2'd0, v); chk("ovr_last", v, 32'h141);

        // Random host traffic against the model.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            logic       rs;
            repeat ($urandom_range(0, 20)) @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                host_write(2'd1, 32'h0, w);
            end else begin
                case ($urandom_range(0, 3))
                    0: b = 8'h01;
                    1: b = 8'h02;
                    2: b = 8'h0C;
                    default: b = 8'($urandom_range(0, 255));
                endcase
                rs = 1'($urandom_range(0, 1));
                host_write(2'd0, {23'b0, rs, b}, w);
            end
            rd(2'd1, v); chk("rand_status", v, exp_st());
        end
        wait_idle(200, t);
        chk("rand_queue_empty", exp_q.size(), 0);
        rd(2'd0, v); chk("rand_last", v, {23'b0, last_rs_m, last_d_m});

        // Reset in the middle of an enable pulse.
        host_write(2'd0, 32'h148, w);
        t = 0;
        while (!lcd_e && t < 20) begin @(negedge clk); t++; end
        chk("mid_e_seen", lcd_e, 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_lcd_e", lcd_e, 0);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_data", {lcd_rs, lcd_data}, 0);
        model_reset();
        np = n_pulses;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_idle(1000, t);
        chk("replay_init_end", t, 226);
        chk("replay_pulses", n_pulses - np, 7);
        rd(2'd1, v); chk("replay_status", v, 32'h2);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/lcd_cmd_sequencer.md
LCD_CMD_SEQUENCER -- requirements
Module: lcd_cmd_sequencer

Interface
REQ-001 Parameter POWERON_CYC, 750000, power-on wait before the first init write (15 ms at 50 MHz).
REQ-002 Parameter SETUP_CYC, 2, RS/data setup cycles before lcd_e rises.
REQ-003 Parameter EPW_CYC, 12, lcd_e high-pulse width in cycles.
REQ-004 Parameter HOLD_CYC, 2, data hold cycles after lcd_e falls.
REQ-005 Parameter EXEC_CYC, 2000, post-write wait for normal commands and data (40 us).
REQ-006 Parameter CLEAR_CYC, 82000, post-write wait for commands 0x01/0x02 (1.64 ms).
REQ-007 Parameter INIT1_CYC, 205000, wait after the first init 0x38 (4.1 ms); the second init 0x38 waits EXEC_CYC*3 cycles.
REQ-008 Port clk, input, 1, system clock; all state updates on its rising edge.
REQ-009 Port reset_n, input, 1, asynchronous active-low reset.
REQ-010 Port address, input, 2, Avalon-MM slave word address.
REQ-011 Port chipselect, input, 1, Avalon-MM slave select.
REQ-012 Port write_n, input, 1, active-low write strobe.
REQ-013 Port writedata, input, 32, write data.
REQ-014 Port readdata, output, 32, combinational read data with zero wait states.
REQ-015 Port lcd_e, output, 1, HD44780 enable strobe.
REQ-016 Port lcd_rs, output, 1, register select (0 = command, 1 = data).
REQ-017 Port lcd_rw, output, 1, read/write select; tied to 0.
REQ-018 Port lcd_data, output, 8, 8-bit LCD data bus.
REQ-019 Port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-020 Address 0 write (chipselect high, write_n low) SHALL be accepted only in IDLE with init_done=1; writedata[7:0] is the byte, writedata[8] is RS.
REQ-021 An address 0 write while busy=1 SHALL be dropped and SHALL set the sticky overrun flag.
REQ-022 An address 1 write SHALL clear the overrun flag; when it coincides with a new overrun event, set SHALL win.
REQ-023 readdata SHALL be {29'b0, overrun, init_done, busy} at address 1, {23'b0, last_rs, last_byte} at address 0, and 0 at addresses 2 and 3.
REQ-024 FSM states: PWR_WAIT, SETUP, E_HIGH, HOLD, EXEC_WAIT, IDLE.
REQ-025 After reset, the FSM SHALL enter PWR_WAIT for POWERON_CYC cycles, then issue the init ROM in order: 0x38, 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, all with RS=0.
REQ-026 Each byte write SHALL follow SETUP -> E_HIGH -> HOLD -> EXEC_WAIT with lengths SETUP_CYC, EPW_CYC, HOLD_CYC and the applicable wait.
REQ-027 lcd_e SHALL be high only in E_HIGH; lcd_rs and lcd_data SHALL stay stable from SETUP entry through HOLD exit.
REQ-028 The EXEC_WAIT length SHALL be CLEAR_CYC when RS=0 and the byte is 0x01 or 0x02, INIT1_CYC after the first init byte, EXEC_CYC*3 after the second init byte, and EXEC_CYC otherwise.
REQ-029 init_done SHALL rise on the cycle EXEC_WAIT ends for the seventh init byte; the FSM then enters IDLE.
REQ-030 An accepted host write SHALL enter SETUP on the next clock; busy SHALL assert on that same edge.
REQ-031 All delay counting SHALL use a single down-counter of at least 20 bits; a parameter value of 0 SHALL be treated as 1 cycle.
REQ-032 lcd_data and lcd_rs SHALL hold the last written values while in IDLE.

Reset
REQ-033 reset_n low SHALL asynchronously force PWR_WAIT, clear the counter, ROM index, overrun, init_done and last_byte/last_rs, and drive lcd_e, lcd_rs and lcd_data to 0 and busy to 1.
REQ-034 Reset asserted mid-pulse SHALL drop lcd_e within the same cycle; after release, the full init sequence SHALL re-run.

Structure
REQ-035 A shared package lcd_pkg SHALL hold the FSM state encoding, the init ROM constants and the command opcodes CLEAR=0x01 and HOME=0x02.
REQ-036 The delay down-counter SHALL be a sub-module named lcd_delay_timer with load, value and done ports.

Verification (simulation parameters: POWERON 20, SETUP 2, EPW 4, HOLD 2, EXEC 10, CLEAR 50, INIT1 30)
REQ-037 Release reset -> lcd_e stays low for 20 cycles, then seven lcd_e pulses with data 38,38,38,38,0C,01,06 are issued, and init_done=1 after the last wait.
REQ-038 After init, write 0x141 to address 0 -> lcd_rs=1 and lcd_data=0x41, lcd_e is high for exactly 4 cycles, and busy drops 18 cycles after the write.
REQ-039 Write 0x001 -> the gap between lcd_e falling and busy falling is 50+2 cycles, versus 10+2 cycles for 0x00C.
REQ-040 A second write while busy -> it is dropped with no extra lcd_e pulse, and address 1 reads 0x7; a write to address 1 then makes address 1 read 0x3.
REQ-041 Assert reset_n in the middle of E_HIGH -> lcd_e falls immediately, and the init sequence replays in full after release.
REQ-042 A write to address 0 before init_done -> it is ignored and the overrun flag is set.
